// File: rtl/vdp_write_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : vdp_write_fifo_param
//  Description : Parametrised CPU-to-video-memory write FIFO. Entries carry
//                address, data and access code. VRAM entries can drain as two
//                byte slots (high byte first). Provides level/full/empty
//                status, a combinational bus stall and a sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module vdp_write_fifo_param #(
    parameter int DEPTH     = 4,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 17,
    parameter int CODE_W    = 4,
    parameter int VRAM_CODE = 1
) (
    input  logic                         MCLK,
    input  logic                         RESET,
    input  logic                         push,
    input  logic [ADDR_W-1:0]            push_addr,
    input  logic [DATA_W-1:0]            push_data,
    input  logic [CODE_W-1:0]            push_code,
    input  logic                         split_en,
    input  logic                         pop,
    input  logic                         clr_ovf,
    output logic [ADDR_W-1:0]            head_addr,
    output logic [DATA_W-1:0]            head_data,
    output logic [DATA_W/2-1:0]          head_byte,
    output logic [CODE_W-1:0]            head_code,
    output logic                         head_phase,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         stall,
    output logic                         overflow
);

    localparam int                  c_PTR_W  = $clog2(DEPTH);
    localparam int                  c_LVL_W  = $clog2(DEPTH+1);
    localparam int                  c_BYTE_W = DATA_W / 2;
    localparam logic [c_LVL_W-1:0]  c_FULL_LVL = c_LVL_W'(DEPTH);
    localparam logic [CODE_W-1:0]   c_VRAM     = CODE_W'(VRAM_CODE);

    // Storage (not reset: contents are don't-care until written)
    logic [ADDR_W-1:0]  r_mem_addr [DEPTH];
    logic [DATA_W-1:0]  r_mem_data [DEPTH];
    logic [CODE_W-1:0]  r_mem_code [DEPTH];

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic               r_phase;
    logic               r_overflow;

    logic               w_empty;
    logic               w_full;
    logic               w_head_split;
    logic               w_deq;
    logic               w_phase_adv;
    logic               w_accept;
    logic               w_drop;
    logic [ADDR_W-1:0]  w_head_addr_raw;
    logic [DATA_W-1:0]  w_head_data;

    assign w_empty         = (r_level == '0);
    assign w_full          = (r_level == c_FULL_LVL);
    assign w_head_addr_raw = r_mem_addr[r_rd_ptr];
    assign w_head_data     = r_mem_data[r_rd_ptr];

    // A head entry splits only when splitting is enabled and it targets VRAM;
    // split_en is sampled live so the decision follows the current pop.
    assign w_head_split = split_en && (r_mem_code[r_rd_ptr] == c_VRAM);

    // Second byte of a split entry always completes, whatever split_en does now.
    assign w_deq       = pop && !w_empty && (!w_head_split || r_phase);
    assign w_phase_adv = pop && !w_empty && w_head_split && !r_phase;

    // A freed slot in the same cycle lets a push into a full FIFO.
    assign w_accept = push && (!w_full || w_deq);
    assign w_drop   = push && w_full && !w_deq;

    // Entry storage write
    always_ff @(posedge MCLK) begin
        if (w_accept) begin
            r_mem_addr[r_wr_ptr] <= push_addr;
            r_mem_data[r_wr_ptr] <= push_data;
            r_mem_code[r_wr_ptr] <= push_code;
        end
    end

    // Pointer, level, byte-phase and overflow bookkeeping
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_phase    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= r_level + c_LVL_W'(w_accept) - c_LVL_W'(w_deq);
            if (w_deq) begin
                r_phase <= 1'b0;
            end else if (w_phase_adv) begin
                r_phase <= 1'b1;
            end
            // A drop in the same cycle as a clear wins
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Head presentation: address LSB selects the byte lane of a split entry
    always_comb begin
        head_addr = w_head_addr_raw;
        if (r_phase) begin
            head_addr[0] = 1'b1;
        end else if (w_head_split) begin
            head_addr[0] = 1'b0;
        end
        head_byte = r_phase ? w_head_data[c_BYTE_W-1:0]
                            : w_head_data[DATA_W-1:c_BYTE_W];
    end

    assign head_data  = w_head_data;
    assign head_code  = r_mem_code[r_rd_ptr];
    assign head_phase = r_phase;
    assign empty      = w_empty;
    assign full       = w_full;
    assign level      = r_level;
    assign stall      = w_drop;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_vdp_write_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vdp_write_fifo_param
//  Description : Self-checking bench for vdp_write_fifo_param: directed
//                vector table, hand sequences and random traffic against a
//                queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vdp_write_fifo_param;

    localparam int DEPTH = 4;
    localparam int VRAM  = 1;

    logic        MCLK = 1'b0;
    logic        RESET;
    logic        push;
    logic [16:0] push_addr;
    logic [15:0] push_data;
    logic [3:0]  push_code;
    logic        split_en;
    logic        pop;
    logic        clr_ovf;
    logic [16:0] head_addr;
    logic [15:0] head_data;
    logic [7:0]  head_byte;
    logic [3:0]  head_code;
    logic        head_phase;
    logic        empty;
    logic        full;
    logic [2:0]  level;
    logic        stall;
    logic        overflow;

    vdp_write_fifo_param #(
        .DEPTH(DEPTH), .DATA_W(16), .ADDR_W(17), .CODE_W(4), .VRAM_CODE(VRAM)
    ) dut (
        .MCLK(MCLK), .RESET(RESET), .push(push), .push_addr(push_addr),
        .push_data(push_data), .push_code(push_code), .split_en(split_en),
        .pop(pop), .clr_ovf(clr_ovf), .head_addr(head_addr),
        .head_data(head_data), .head_byte(head_byte), .head_code(head_code),
        .head_phase(head_phase), .empty(empty), .full(full), .level(level),
        .stall(stall), .overflow(overflow)
    );

    always #5 MCLK = ~MCLK;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: an ordered queue of entries plus byte phase and flag
    typedef struct {
        logic [16:0] addr;
        logic [15:0] data;
        logic [3:0]  code;
    } ent_t;
    ent_t m_q[$];
    logic m_phase = 1'b0;
    logic m_ovf   = 1'b0;

    typedef struct {
        logic        p;
        logic [16:0] a;
        logic [15:0] d;
        logic [3:0]  c;
        logic        s;
        logic        po;
        logic        cl;
        int          lvl;
        logic        st;
        logic        ov;
        logic        hc;
        logic [15:0] hd;
        logic [7:0]  hb;
        logic [16:0] ha;
        logic        ph;
    } vec_t;
    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic head_splits();
        return (m_q.size() > 0) && split_en && (m_q[0].code == 4'(VRAM));
    endfunction

    function automatic logic model_deq();
        return pop && (m_q.size() > 0) && (!head_splits() || m_phase);
    endfunction

    // Compare every DUT output with the model for the currently driven inputs
    task automatic model_check();
        int          sz;
        logic [16:0] ea;
        sz = m_q.size();
        chk("level", 32'(level), 32'(sz));
        chk("empty", 32'(empty), 32'(sz == 0));
        chk("full", 32'(full), 32'(sz == DEPTH));
        chk("stall", 32'(stall), 32'(push && sz == DEPTH && !model_deq()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("head_phase", 32'(head_phase), 32'(m_phase));
        if (sz > 0) begin
            ea = m_q[0].addr;
            if (m_phase) ea[0] = 1'b1;
            else if (head_splits()) ea[0] = 1'b0;
            chk("head_data", 32'(head_data), 32'(m_q[0].data));
            chk("head_code", 32'(head_code), 32'(m_q[0].code));
            chk("head_addr", 32'(head_addr), 32'(ea));
            chk("head_byte", 32'(head_byte),
                32'(m_phase ? m_q[0].data[7:0] : m_q[0].data[15:8]));
        end
    endtask

    // Apply the clock-edge effect of the current inputs to the model
    task automatic model_update();
        logic fl, dq, sp;
        ent_t e;
        fl = (m_q.size() == DEPTH);
        dq = model_deq();
        sp = head_splits();
        if (push && fl && !dq) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
        if (dq) begin
            void'(m_q.pop_front());
            m_phase = 1'b0;
        end else if (pop && m_q.size() > 0 && sp) begin
            m_phase = 1'b1;
        end
        if (push && (!fl || dq)) begin
            e.addr = push_addr;
            e.data = push_data;
            e.code = push_code;
            m_q.push_back(e);
        end
    endtask

    // Drive inputs just after an edge, then check at the falling edge
    task automatic drive(input logic p, input logic [16:0] a, input logic [15:0] d,
                         input logic [3:0] c, input logic s, input logic po,
                         input logic cl);
        push = p; push_addr = a; push_data = d; push_code = c;
        split_en = s; pop = po; clr_ovf = cl;
        @(negedge MCLK);
        model_check();
    endtask

    task automatic advance();
        model_update();
        @(posedge MCLK);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        advance();
    endtask

    task automatic addv(input logic p, input logic [16:0] a, input logic [15:0] d,
                        input logic [3:0] c, input logic s, input logic po, input logic cl,
                        input int lvl, input logic st, input logic ov, input logic hc,
                        input logic [15:0] hd, input logic [7:0] hb,
                        input logic [16:0] ha, input logic ph);
        vec_t v;
        v.p = p; v.a = a; v.d = d; v.c = c; v.s = s; v.po = po; v.cl = cl;
        v.lvl = lvl; v.st = st; v.ov = ov; v.hc = hc;
        v.hd = hd; v.hb = hb; v.ha = ha; v.ph = ph;
        vq.push_back(v);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        #2;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_phase", 32'(head_phase), 32'd0);
        m_q.delete();
        m_phase = 1'b0;
        m_ovf   = 1'b0;
        @(posedge MCLK);
        #1;
        RESET = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        push = 0; push_addr = '0; push_data = '0; push_code = '0;
        split_en = 0; pop = 0; clr_ovf = 0;
        repeat (2) @(posedge MCLK);
        #1;
        do_reset();
        chk("rst_stall", 32'(stall), 32'd0);

        // ---------------- directed vector table ----------------
        //    p  addr      data      c  s  po cl  lvl st ov hc head      byte   haddr     ph
        addv(1, 17'h100, 16'hABCD, 1, 1, 0, 0,  0, 0, 0, 0, 16'h0,    8'h0,  17'h0,    0);
        addv(0, 17'h0,   16'h0,    0, 1, 1, 0,  1, 0, 0, 1, 16'hABCD, 8'hAB, 17'h100,  0);
        addv(0, 17'h0,   16'h0,    0, 1, 1, 0,  1, 0, 0, 1, 16'hABCD, 8'hCD, 17'h101,  1);
        addv(0, 17'h0,   16'h0,    0, 1, 0, 0,  0, 0, 0, 0, 16'h0,    8'h0,  17'h0,    0);
        addv(1, 17'h200, 16'h1111, 3, 1, 0, 0,  0, 0, 0, 0, 16'h0,    8'h0,  17'h0,    0);
        addv(1, 17'h201, 16'h2222, 3, 1, 0, 0,  1, 0, 0, 1, 16'h1111, 8'h11, 17'h200,  0);
        addv(1, 17'h202, 16'h3333, 3, 1, 0, 0,  2, 0, 0, 1, 16'h1111, 8'h11, 17'h200,  0);
        addv(1, 17'h203, 16'h4444, 3, 1, 0, 0,  3, 0, 0, 1, 16'h1111, 8'h11, 17'h200,  0);
        addv(1, 17'h300, 16'h5555, 3, 1, 0, 0,  4, 1, 0, 1, 16'h1111, 8'h11, 17'h200,  0);
        addv(0, 17'h0,   16'h0,    0, 1, 0, 0,  4, 0, 1, 1, 16'h1111, 8'h11, 17'h200,  0);
        addv(0, 17'h0,   16'h0,    0, 1, 0, 1,  4, 0, 1, 1, 16'h1111, 8'h11, 17'h200,  0);
        addv(1, 17'h300, 16'h5555, 3, 1, 1, 0,  4, 0, 0, 1, 16'h1111, 8'h11, 17'h200,  0);
        addv(0, 17'h0,   16'h0,    0, 1, 1, 0,  4, 0, 0, 1, 16'h2222, 8'h22, 17'h201,  0);
        addv(0, 17'h0,   16'h0,    0, 1, 1, 0,  3, 0, 0, 1, 16'h3333, 8'h33, 17'h202,  0);
        addv(0, 17'h0,   16'h0,    0, 1, 1, 0,  2, 0, 0, 1, 16'h4444, 8'h44, 17'h203,  0);
        addv(0, 17'h0,   16'h0,    0, 1, 1, 0,  1, 0, 0, 1, 16'h5555, 8'h55, 17'h300,  0);
        addv(0, 17'h0,   16'h0,    0, 1, 0, 0,  0, 0, 0, 0, 16'h0,    8'h0,  17'h0,    0);
        addv(1, 17'h350, 16'h7777, 3, 1, 1, 0,  0, 0, 0, 0, 16'h0,    8'h0,  17'h0,    0);
        addv(0, 17'h0,   16'h0,    0, 1, 0, 0,  1, 0, 0, 1, 16'h7777, 8'h77, 17'h350,  0);
        addv(0, 17'h0,   16'h0,    0, 1, 1, 0,  1, 0, 0, 1, 16'h7777, 8'h77, 17'h350,  0);
        addv(0, 17'h0,   16'h0,    0, 1, 0, 0,  0, 0, 0, 0, 16'h0,    8'h0,  17'h0,    0);
        addv(1, 17'h401, 16'hBEEF, 1, 1, 0, 0,  0, 0, 0, 0, 16'h0,    8'h0,  17'h0,    0);
        addv(0, 17'h0,   16'h0,    0, 1, 1, 0,  1, 0, 0, 1, 16'hBEEF, 8'hBE, 17'h400,  0);
        addv(0, 17'h0,   16'h0,    0, 0, 1, 0,  1, 0, 0, 1, 16'hBEEF, 8'hEF, 17'h401,  1);
        addv(0, 17'h0,   16'h0,    0, 1, 0, 0,  0, 0, 0, 0, 16'h0,    8'h0,  17'h0,    0);

        foreach (vq[i]) begin
            drive(vq[i].p, vq[i].a, vq[i].d, vq[i].c, vq[i].s, vq[i].po, vq[i].cl);
            chk($sformatf("vec%0d_level", i), 32'(level), 32'(vq[i].lvl));
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vq[i].st));
            chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vq[i].ov));
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vq[i].lvl == 0));
            chk($sformatf("vec%0d_full", i), 32'(full), 32'(vq[i].lvl == DEPTH));
            if (vq[i].hc) begin
                chk($sformatf("vec%0d_hdata", i), 32'(head_data), 32'(vq[i].hd));
                chk($sformatf("vec%0d_hbyte", i), 32'(head_byte), 32'(vq[i].hb));
                chk($sformatf("vec%0d_haddr", i), 32'(head_addr), 32'(vq[i].ha));
                chk($sformatf("vec%0d_phase", i), 32'(head_phase), 32'(vq[i].ph));
            end
            advance();
        end

        // ---------------- wrap: push/drain pairs, alternating split ----------------
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 17'(20'h10 + i * 3), 16'(16'hA000 + i * 16'h0111),
                  (i % 2 == 1) ? 4'(VRAM) : 4'd3, 1'b1, 1'b0, 1'b0);
            advance();
            for (int j = 0; j < 3; j++) begin
                drive(1'b0, '0, '0, '0, 1'b1, (m_q.size() > 0), 1'b0);
                advance();
            end
        end
        chk("wrap_empty", 32'(empty), 32'd1);

        // ---------------- randomized traffic ----------------
        for (int k = 0; k < 3000; k++) begin
            drive(($urandom_range(0, 9) < 6), 17'($urandom), 16'($urandom),
                  4'($urandom_range(0, 2)), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 9) < 5), ($urandom_range(0, 19) == 0));
            advance();
        end

        // ---------------- reset in the middle of operation ----------------
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 17'(i), 16'(16'h0101 * (i + 1)), 4'd3, 1'b1, 1'b0, 1'b0);
            advance();
        end
        drive(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
        advance();
        chk("pre_rst_level", 32'(level), 32'd3);
        chk("pre_rst_ovf", 32'(overflow), 32'd1);
        do_reset();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
